// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Imported by mem_arbiter and rr_pick2.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W      = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: bit0 = CPU, bit1 = IO.
// On a tie the requester that did not win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11):
        gnt_o = (last_i == OWN_CPU) ? 2'b10 : 2'b01;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and IO requesters onto one memory port.
// Writes take one cycle; reads wait MEM_LAT cycles for data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              io_req,
  input  logic              cpu_we,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              cpu_gnt,
  output logic              io_gnt,
  output logic              cpu_rvalid,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_e           own_q, own_d;
  owner_e           last_q, last_d;

  logic [1:0] pick;
  logic       win_io;
  logic       win_we;

  rr_pick2 u_pick (
    .req_i  ({io_req, cpu_req}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign win_io = pick[1];
  assign win_we = win_io ? io_we : cpu_we;

  assign cpu_rdata = mem_rdata;
  assign io_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      own_q   <= OWN_CPU;
      last_q  <= OWN_IO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          last_d = win_io ? OWN_IO : OWN_CPU;
          if (!win_we) begin
            state_d = ST_WAIT;
            cnt_d   = LAT_LD;
            own_d   = win_io ? OWN_IO : OWN_CPU;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset since the state register clears one edge late.
  always_comb begin
    cpu_gnt    = 1'b0;
    io_gnt     = 1'b0;
    cpu_rvalid = 1'b0;
    io_rvalid  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          cpu_gnt   = pick[0];
          io_gnt    = pick[1];
          mem_en    = |pick;
          mem_we    = (|pick) & win_we;
          mem_addr  = win_io ? io_addr : cpu_addr;
          mem_wdata = win_io ? io_wdata : cpu_wdata;
        end
        ST_WAIT: begin
          busy = 1'b1;
          if (cnt_q == ONE) begin
            cpu_rvalid = (own_q == OWN_CPU);
            io_rvalid  = (own_q == OWN_IO);
          end
        end
        default: busy = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory data width (byte-wide lb/sb datapath).
REQ-002 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-003 SHALL have parameter MEM_LAT, default 1, read latency in cycles (legal range 1..4).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports cpu_req and io_req, input, 1, access request from the controller and the countdown I/O requester.
REQ-007 SHALL have ports cpu_we and io_we, input, 1, 1=write and 0=read, qualified by the matching req.
REQ-008 SHALL have ports cpu_addr and io_addr, input, ADDR_W, access address.
REQ-009 SHALL have ports cpu_wdata and io_wdata, input, DATA_W, write data.
REQ-010 SHALL have ports cpu_gnt and io_gnt, output, 1, request accepted this cycle.
REQ-011 SHALL have ports cpu_rvalid and io_rvalid, output, 1, read data valid this cycle.
REQ-012 SHALL have ports cpu_rdata and io_rdata, output, DATA_W, driven directly from mem_rdata and meaningful only while the matching rvalid is high.
REQ-013 SHALL have ports mem_en and mem_we, output, 1, memory access strobe and write enable.
REQ-014 SHALL have ports mem_addr (ADDR_W) and mem_wdata (DATA_W), output, carrying the muxed address and write data.
REQ-015 SHALL have port mem_rdata, input, DATA_W, memory read data, valid MEM_LAT cycles after mem_en.
REQ-016 SHALL have port busy, output, 1, asserted when the state is WAIT.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-018 SHALL, in IDLE with at least one req high, grant exactly one requester in the same cycle (combinational gnt), assert mem_en, and drive mem_we/mem_addr/mem_wdata from the winner.
REQ-019 SHALL, in IDLE with both req high, grant the requester that is not last_owner; last_owner SHALL update to the winner on every grant.
REQ-020 SHALL return a write grant to IDLE with no rvalid, so a write completes in 1 cycle.
REQ-021 SHALL move a read grant to WAIT and load the latency counter with MEM_LAT; the counter SHALL decrement once per WAIT cycle.
REQ-022 SHALL, in WAIT, assert no gnt and hold mem_en=0; any req during WAIT remains pending.
REQ-023 SHALL, in the WAIT cycle where the counter reaches 1, assert the owner's rvalid for exactly one cycle and return to IDLE next, so the owner sees rvalid exactly MEM_LAT cycles after gnt.
REQ-024 SHALL ensure a read costs 1+MEM_LAT cycles, and back-to-back grants to the same requester occur only if the other requester is idle.
REQ-025 SHALL never assert cpu_gnt and io_gnt together, and never assert cpu_rvalid and io_rvalid together.
REQ-026 SHALL treat a req still high in the IDLE cycle after its grant as a new request; requesters drop req after gnt unless they want another access.
REQ-027 SHALL, when both requesters keep req high continuously, alternate grants so neither waits more than one access.

Reset
REQ-028 SHALL, while reset is high, drive state=IDLE, counter=0, last_owner=IO (so the CPU wins the first tie), and force all gnt, rvalid, mem_en, mem_we and busy outputs to 0 regardless of req.
REQ-029 SHALL, on reset mid-read, abandon the access with no rvalid, leave the next cycle after reset release arbitrating from IDLE, and ignore stale mem_rdata.

Structure
REQ-030 SHALL place the state encoding (IDLE/WAIT), the owner encoding (CPU/IO) and the DATA_W/ADDR_W defaults in the shared package mem_arb_pkg.
REQ-031 SHALL place the two-way round-robin choice (req pair and last_owner in, one-hot grant out) in one combinational sub-module, rr_pick2.

Verification
REQ-032 SHALL check: reset, then cpu_req=1, cpu_we=0, cpu_addr=0x10 with MEM_LAT=1 -> cpu_gnt and mem_en in the same cycle, mem_addr=0x10, cpu_rvalid 1 cycle later with cpu_rdata=memory[0x10].
REQ-033 SHALL check: cpu_req and io_req both high on the first cycle after reset -> CPU granted first, IO granted in the first IDLE cycle afterward, then alternating while both are held.
REQ-034 SHALL check: io write of 0x5A to 0x20, then cpu read of 0x20 -> 1-cycle write with mem_we=1, then cpu_rdata=0x5A.
REQ-035 SHALL check: MEM_LAT=3 with cpu read granted and io_req rising during WAIT -> busy high for 3 cycles, no io_gnt until after cpu_rvalid, io_gnt on the next IDLE cycle.
REQ-036 SHALL check: reset asserted during WAIT of a read -> no rvalid ever issued for that access, all outputs 0 during reset, and a normal grant on the first cycle after release.
